// File: rtl/lsu.sv
// Load/store unit: sits between execute and the single-port synchronous data
// memory. Handles byte/half/word accesses, splits misaligned ones into two
// word beats, and returns extended load data with a one-cycle valid pulse.

package lsu_pkg;
   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } MemControlT;
endpackage

module lsu
   import lsu_pkg::*;
#(
   parameter int MEM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  MemControlT           req_control,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 req_ready,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_valid,
   output logic [MEM_WIDTH-1:0] mem_addr,
   output logic                 mem_we,
   output logic [3:0]           mem_be,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD1, RD2, WR2} state_t;

   state_t state, state_nxt;

   // Request context held across the second beat of a split access.
   logic [1:0]           off_q;
   logic [2:0]           funct3_q;
   logic [31:0]          wdata_q;
   logic [MEM_WIDTH-1:0] word_q;
   logic [31:0]          word1_q;

   logic [1:0]           req_off;
   logic [MEM_WIDTH-1:0] req_word;
   logic                 req_split;
   logic                 hold_split;
   logic                 unused_addr_bits;

   logic [1:0]           st_off;
   logic [2:0]           st_funct3;
   logic [31:0]          st_data;
   logic [7:0]           be_wide;
   logic [63:0]          wd_wide;

   logic [31:0]          ld_lo;
   logic [31:0]          ld_word;
   logic [31:0]          ld_ext;

   logic                 we_c;
   logic                 rsp_set;

   // funct3[1:0]: 00 byte, 01 half, anything else a full word.
   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      unique case (f3[1:0])
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // An access is split when its bytes run past lane 3 of the first word.
   function automatic logic is_split(input logic [2:0] f3, input logic [1:0] o);
      unique case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return (o == 2'd3);
         default: return (o != 2'd0);
      endcase
   endfunction

   assign req_off          = req_addr[1:0];
   assign req_word         = req_addr[MEM_WIDTH+1:2];
   assign req_split        = is_split(req_funct3, req_off);
   assign hold_split       = is_split(funct3_q, off_q);
   assign unused_addr_bits = ^req_addr[31:MEM_WIDTH+2];
   assign req_ready        = (state == IDLE);

   // Store lane steering: shifting into a double-width vector gives beat 1 in
   // the low half and beat 2 in the high half from one shifter.
   assign st_off    = (state == WR2) ? off_q    : req_off;
   assign st_funct3 = (state == WR2) ? funct3_q : req_funct3;
   assign st_data   = (state == WR2) ? wdata_q  : req_wdata;
   assign be_wide   = {4'b0000, size_mask(st_funct3)} << st_off;
   assign wd_wide   = {32'h0, st_data} << {st_off, 3'b000};

   // Load assembly: {word2, word1} shifted down by the byte offset. For an
   // unsplit access only the low part matters, so mem_rdata fills both halves.
   assign ld_lo   = (state == RD2) ? word1_q : mem_rdata;
   assign ld_word = 32'({mem_rdata, ld_lo} >> {off_q, 3'b000});

   // Sign- or zero-extend the assembled load; funct3[2] selects unsigned.
   always_comb begin
      ld_ext = ld_word;
      unique case (funct3_q[1:0])
         2'b00:   ld_ext = {{24{~funct3_q[2] & ld_word[7]}}, ld_word[7:0]};
         2'b01:   ld_ext = {{16{~funct3_q[2] & ld_word[15]}}, ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
   end

   // Next-state and memory-port drive for the beat sequencer.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_nxt = state;
      mem_addr  = word_q + MEM_WIDTH'(1);
      we_c      = 1'b0;
      mem_be    = be_wide[3:0];
      mem_wdata = wd_wide[31:0];
      rsp_set   = 1'b0;
      unique case (state)
         IDLE: begin
            mem_addr = req_word;
            if (req_control == MEM_WRITE) begin
               we_c = 1'b1;
               if (req_split) state_nxt = WR2;
            end else if (req_control == MEM_READ) begin
               state_nxt = RD1;
            end
         end
         RD1: begin
            if (hold_split) begin
               state_nxt = RD2;
            end else begin
               state_nxt = IDLE;
               rsp_set   = 1'b1;
            end
         end
         RD2: begin
            state_nxt = IDLE;
            rsp_set   = 1'b1;
         end
         WR2: begin
            we_c      = 1'b1;
            mem_be    = be_wide[7:4];
            mem_wdata = wd_wide[63:32];
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset must block writes at once, even before the state register clears.
   assign mem_we = we_c & rst;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Request capture, first-word capture and response register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         off_q     <= '0;
         funct3_q  <= '0;
         wdata_q   <= '0;
         word_q    <= '0;
         word1_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= rsp_set;
         if (rsp_set) rsp_rdata <= ld_ext;
         if (state == IDLE && (req_control == MEM_READ || req_control == MEM_WRITE)) begin
            off_q    <= req_off;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            word_q   <= req_word;
         end
         if (state == RD1) word1_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed steps followed by random traffic,
// compared against a byte-addressed reference memory.

module tb_lsu;
   import lsu_pkg::*;

   localparam int MW     = 16;
   localparam int NWORDS = 1 << MW;
   localparam int NBYTES = NWORDS * 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   MemControlT    req_control = MEM_NONE;
   logic [2:0]    req_funct3  = 3'd0;
   logic [31:0]   req_addr    = 32'd0;
   logic [31:0]   req_wdata   = 32'd0;
   logic          req_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_valid;
   logic [MW-1:0] mem_addr;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = 32'd0;

   int checks = 0;
   int errors = 0;

   bit [31:0] dmem    [NWORDS];   // memory the DUT talks to
   bit [7:0]  ref_mem [NBYTES];   // reference view, one byte per entry

   always #5 clk = ~clk;

   lsu #(.MEM_WIDTH(MW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_control (req_control),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_valid   (rsp_valid),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Synchronous single-port data memory with byte enables.
   always @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) dmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= dmem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] bidx(input logic [31:0] a, input int i);
      return (a + 32'(i)) & 32'(NBYTES - 1);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v = 32'd0;
      int n = nbytes(f3);
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[bidx(a, i)];
      if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   // Write the store's bytes; first_only keeps just those landing in the first word.
   function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] d, input bit first_only);
      logic [31:0] b;
      logic [31:0] a0 = bidx(a, 0);
      for (int i = 0; i < nbytes(f3); i++) begin
         b = bidx(a, i);
         if (!first_only || (b >> 2) == (a0 >> 2)) ref_mem[b] = d[8*i +: 8];
      end
   endfunction

   function automatic logic [31:0] ref_word(input logic [MW-1:0] w);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[4*int'(w) + i];
      return v;
   endfunction

   // Lanes and data a store should put into one given word.
   function automatic void exp_beat(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d, input logic [MW-1:0] word,
                                    output logic [3:0] be, output logic [31:0] wd);
      logic [31:0] b;
      be = 4'd0;
      wd = 32'd0;
      for (int i = 0; i < nbytes(f3); i++) begin
         b = bidx(a, i);
         if (b[MW+1:2] == word) begin
            be[b[1:0]] = 1'b1;
            wd[8*b[1:0] +: 8] = d[8*i +: 8];
         end
      end
   endfunction

   function automatic logic [31:0] lanes(input logic [3:0] be);
      logic [31:0] m = 32'd0;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // One full transaction. Entered and left just after a falling edge.
   task automatic issue(input MemControlT c, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      logic [31:0]   ab  = bidx(a, 0);
      bit            mis = (int'(ab[1:0]) + nbytes(f3)) > 4;
      logic [MW-1:0] w   = ab[MW+1:2];
      logic [MW-1:0] w2  = w + MW'(1);
      logic [3:0]    be;
      logic [31:0]   wd;
      logic [31:0]   exp;
      int            cyc;
      req_control = c;
      req_funct3  = f3;
      req_addr    = a;
      req_wdata   = d;
      #1;
      check("ready_at_req", 32'(req_ready), 32'd1);
      check("beat1_addr", 32'(mem_addr), 32'(w));
      if (c == MEM_WRITE) begin
         exp_beat(f3, a, d, w, be, wd);
         check("beat1_we", 32'(mem_we), 32'd1);
         check("beat1_be", 32'(mem_be), 32'(be));
         check("beat1_data", mem_wdata & lanes(be), wd);
         @(negedge clk);
         req_control = MEM_NONE;
         #1;
         if (mis) begin
            exp_beat(f3, a, d, w2, be, wd);
            check("wr2_ready", 32'(req_ready), 32'd0);
            check("beat2_we", 32'(mem_we), 32'd1);
            check("beat2_addr", 32'(mem_addr), 32'(w2));
            check("beat2_be", 32'(mem_be), 32'(be));
            check("beat2_data", mem_wdata & lanes(be), wd);
            @(negedge clk);
            #1;
         end
         check("store_ready_after", 32'(req_ready), 32'd1);
         ref_store(f3, a, d, 1'b0);
         check("mem_word1", dmem[w], ref_word(w));
         if (mis) check("mem_word2", dmem[w2], ref_word(w2));
      end else begin
         exp = ref_load(f3, a);
         check("load_we", 32'(mem_we), 32'd0);
         @(negedge clk);
         req_control = MEM_NONE;
         #1;
         check("rd_busy", 32'(req_ready), 32'd0);
         check("rd_no_early_rsp", 32'(rsp_valid), 32'd0);
         if (mis) begin
            check("rd2_addr", 32'(mem_addr), 32'(w2));
            check("rd2_we", 32'(mem_we), 32'd0);
         end
         cyc = 1;
         while (!rsp_valid && cyc < 6) begin
            @(negedge clk);
            #1;
            cyc++;
         end
         check("load_latency", 32'(cyc), mis ? 32'd3 : 32'd2);
         check("load_data", rsp_rdata, exp);
         check("ready_with_rsp", 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f3;
      logic [31:0] hold;

      // Reset with a write pending: the write strobe must stay low.
      req_control = MEM_WRITE;
      req_funct3  = 3'b010;
      req_addr    = 32'h10;
      req_wdata   = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      #1;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      req_control = MEM_NONE;
      rst = 1'b1;
      @(negedge clk);
      #1;

      // Aligned word store and load back.
      issue(MEM_WRITE, 3'b010, 32'h10, 32'hDEAD_BEEF);
      check("sw_word4", dmem[4], 32'hDEAD_BEEF);
      issue(MEM_READ, 3'b010, 32'h10, 32'h0);
      check("lw_value", rsp_rdata, 32'hDEAD_BEEF);

      // Byte in lane 3, signed and unsigned loads.
      issue(MEM_WRITE, 3'b000, 32'h13, 32'h80);
      issue(MEM_READ, 3'b000, 32'h13, 32'h0);
      check("lb_value", rsp_rdata, 32'hFFFF_FF80);
      issue(MEM_READ, 3'b100, 32'h13, 32'h0);
      check("lbu_value", rsp_rdata, 32'h0000_0080);

      // Misaligned word store and load.
      issue(MEM_WRITE, 3'b010, 32'h0E, 32'h1122_3344);
      issue(MEM_READ, 3'b010, 32'h0E, 32'h0);
      check("lw_split_value", rsp_rdata, 32'h1122_3344);

      // Half-word straddling words 7 and 8.
      issue(MEM_WRITE, 3'b000, 32'h1F, 32'h34);
      issue(MEM_WRITE, 3'b000, 32'h20, 32'h92);
      issue(MEM_READ, 3'b001, 32'h1F, 32'h0);
      check("lh_split_value", rsp_rdata, 32'hFFFF_9234);
      issue(MEM_READ, 3'b101, 32'h1F, 32'h0);
      check("lhu_split_value", rsp_rdata, 32'h0000_9234);
      @(negedge clk);
      #1;
      check("rsp_pulse_ends", 32'(rsp_valid), 32'd0);
      check("rdata_holds", rsp_rdata, 32'h0000_9234);

      // Split at the top of memory wraps to word 0.
      issue(MEM_WRITE, 3'b010, 32'h3FFFE, 32'hCAFE_F00D);
      issue(MEM_READ, 3'b010, 32'h3FFFE, 32'h0);
      check("wrap_value", rsp_rdata, 32'hCAFE_F00D);

      // Prefill a small window, then random traffic over it and the top.
      for (int i = 0; i < 36; i++) issue(MEM_WRITE, 3'b010, 32'(4 * i), $urandom);
      issue(MEM_WRITE, 3'b010, 32'h3FFF8, $urandom);
      issue(MEM_WRITE, 3'b010, 32'h3FFFC, $urandom);
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 9) == 0) a = 32'h3FFF8 + 32'($urandom_range(0, 7));
         else                           a = 32'($urandom_range(0, 140));
         if ($urandom_range(0, 3) == 0) a[31:18] = 14'($urandom);
         f3 = 3'($urandom_range(0, 7));
         d  = $urandom;
         issue($urandom_range(0, 1) ? MEM_READ : MEM_WRITE, f3, a, d);
      end

      // Reset while the second store beat is on the bus.
      issue(MEM_READ, 3'b010, 32'h10, 32'h0);
      hold = rsp_rdata;
      a = 32'h26;
      d = 32'hA5A5_5A5A ^ hold;
      req_control = MEM_WRITE;
      req_funct3  = 3'b010;
      req_addr    = a;
      req_wdata   = d;
      @(negedge clk);
      req_control = MEM_NONE;
      #1;
      check("mid_wr2_we", 32'(mem_we), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_kills_we", 32'(mem_we), 32'd0);
      ref_store(3'b010, a, d, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_rdata", rsp_rdata, 32'd0);
      check("beat1_kept", dmem[9], ref_word(MW'(9)));
      check("beat2_dropped", dmem[10], ref_word(MW'(10)));
      issue(MEM_READ, 3'b010, a, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
